mult_arbiter: RTL

Sequencer and arbiter for the shared 8-bit `Multiplier` datapath. Two requesters (e.g. the keypad/switch front end and the self-test/replay path) each submit an operand pair over a req/ack handshake. The block grants one requester at a time in round-robin order, pulses the multiplier's `start`, waits for `done` under a watchdog, and returns the latched result and sign on a shared response bus. It sits between the requesters and the `Multiplier` instance; the display path consumes its response bus.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/mult_arbiter_if.sv | 31 +++
 rtl/mult_rr_arb.sv | 27 ++
 rtl/mult_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the multiplier sequencer/arbiter.
package mult_pkg;

  localparam int unsigned DataWDef   = 8;
  localparam int unsigned ResWDef    = 14;
  localparam int unsigned TimeoutDef = 64;
  localparam int unsigned SignW      = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  // Wait counter width; never below one bit so tiny timeouts still synthesize.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

  localparam int unsigned CntWDef = cnt_width(TimeoutDef);

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side handshake and shared response bus of the multiplier arbiter.
interface mult_arbiter_if #(
  parameter int unsigned DATA_W = mult_pkg::DataWDef,
  parameter int unsigned RES_W  = mult_pkg::ResWDef
);

  logic                       req0;
  logic                       req1;
  logic [DATA_W-1:0]          a0;
  logic [DATA_W-1:0]          b0;
  logic [DATA_W-1:0]          a1;
  logic [DATA_W-1:0]          b1;
  logic                       ack0;
  logic                       ack1;
  logic [RES_W-1:0]           rsp_result;
  logic [mult_pkg::SignW-1:0] rsp_sign;
  logic                       rsp_err;

  // Requester view.
  modport master (
    output req0, req1, a0, b0, a1, b1,
    input  ack0, ack1, rsp_result, rsp_sign, rsp_err
  );

  // Arbiter view.
  modport slave (
    input  req0, req1, a0, b0, a1, b1,
    output ack0, ack1, rsp_result, rsp_sign, rsp_err
  );

endinterface

// File: rtl/mult_rr_arb.sv
// Two-way round-robin grant; the mask blocks the last-served requester for one cycle.
module mult_rr_arb (
  input  logic req0,
  input  logic req1,
  input  logic mask,
  input  logic grant_id,
  output logic gnt_vld,
  output logic gnt_id
);

  logic eff0;
  logic eff1;

  // Apply the mask, then break a tie against the requester served last.
  always_comb begin
    eff0    = req0 & ~(mask & ~grant_id);
    eff1    = req1 & ~(mask & grant_id);
    gnt_vld = eff0 | eff1;
    gnt_id  = 1'b0;
    if (eff0 && eff1) begin
      gnt_id = ~grant_id;
    end else if (eff1) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Sequencer/arbiter in front of the shared Multiplier: grants one requester,
// pulses start, waits for done under a watchdog and returns the result.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int unsigned DATA_W  = DataWDef,
  parameter int unsigned RES_W   = ResWDef,
  parameter int unsigned TIMEOUT = TimeoutDef
) (
  input  logic              clock,
  input  logic              rst_n,
  mult_arbiter_if.slave     bus,
  output logic              mul_start,
  output logic [DATA_W-1:0] mul_multiplier,
  output logic [DATA_W-1:0] mul_multiplicand,
  input  logic              mul_done,
  input  logic [RES_W-1:0]  mul_result,
  input  logic [SignW-1:0]  mul_sign,
  output logic              busy,
  output logic              grant_id
);

  localparam int unsigned CntW = cnt_width(TIMEOUT);

  state_e            state_q;
  logic              mask_q;
  logic [CntW-1:0]   wait_cnt_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              start_q;
  logic              busy_q;
  logic              grant_id_q;
  logic [DATA_W-1:0] mul_a_q;
  logic [DATA_W-1:0] mul_b_q;
  logic [RES_W-1:0]  rsp_result_q;
  logic [SignW-1:0]  rsp_sign_q;
  logic              rsp_err_q;

  logic gnt_vld;
  logic gnt_id;
  logic done_ok;
  logic expired;

  mult_rr_arb u_rr_arb (
    .req0     (bus.req0),
    .req1     (bus.req1),
    .mask     (mask_q),
    .grant_id (grant_id_q),
    .gnt_vld  (gnt_vld),
    .gnt_id   (gnt_id)
  );

  // A done level in the first WAIT cycle may be left over from a previous op.
  assign done_ok = mul_done && (wait_cnt_q != '0);
  assign expired = (wait_cnt_q == CntW'(TIMEOUT - 1));

  // Control FSM with all outputs registered.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mask_q       <= 1'b0;
      wait_cnt_q   <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      grant_id_q   <= 1'b1;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_sign_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          mask_q <= 1'b0;
          if (gnt_vld) begin
            state_q    <= StIssue;
            busy_q     <= 1'b1;
            start_q    <= 1'b1;
            grant_id_q <= gnt_id;
            mul_a_q    <= gnt_id ? bus.a1 : bus.a0;
            mul_b_q    <= gnt_id ? bus.b1 : bus.b0;
          end
        end
        StIssue: begin
          state_q    <= StWait;
          wait_cnt_q <= '0;
        end
        StWait: begin
          if (done_ok) begin
            state_q      <= StResp;
            rsp_result_q <= mul_result;
            rsp_sign_q   <= mul_sign;
            rsp_err_q    <= 1'b0;
            ack0_q       <= ~grant_id_q;
            ack1_q       <= grant_id_q;
          end else if (expired) begin
            state_q      <= StResp;
            rsp_result_q <= '0;
            rsp_sign_q   <= '0;
            rsp_err_q    <= 1'b1;
            ack0_q       <= ~grant_id_q;
            ack1_q       <= grant_id_q;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        StResp: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          mask_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mul_start        = start_q;
  assign mul_multiplier   = mul_a_q;
  assign mul_multiplicand = mul_b_q;
  assign busy             = busy_q;
  assign grant_id         = grant_id_q;
  assign bus.ack0         = ack0_q;
  assign bus.ack1         = ack1_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_sign     = rsp_sign_q;
  assign bus.rsp_err      = rsp_err_q;

endmodule
